// File: rtl/nav_pkg.sv
// nav_pkg: shared direction codes, FSM state encoding and elaboration helpers
//   DIR_*      one-hot motor direction codes used by the motor driver and top level
//   state_t    navigation FSM state encoding
//   dir_of     maps a state to the direction code it drives
//   cycles_ok  true when a phase length fits a TIMER_W-bit down-counter
package nav_pkg;
    localparam logic [4:0] DIR_FORWARD  = 5'b00001;
    localparam logic [4:0] DIR_BACKWARD = 5'b00010;
    localparam logic [4:0] DIR_LEFT     = 5'b00100;
    localparam logic [4:0] DIR_RIGHT    = 5'b01000;
    localparam logic [4:0] DIR_STOP     = 5'b10000;

    typedef enum logic [2:0] {
        S_IDLE, S_FORWARD, S_BRAKE, S_REVERSE, S_TURN_L, S_TURN_R, S_FAULT
    } state_t;

    function automatic logic [4:0] dir_of(input state_t s);
        return s == S_FORWARD ? DIR_FORWARD :
               s == S_REVERSE ? DIR_BACKWARD :
               s == S_TURN_L  ? DIR_LEFT :
               s == S_TURN_R  ? DIR_RIGHT : DIR_STOP;
    endfunction

    function automatic logic cycles_ok(input longint n, input int w);
        return n >= 1 && n <= (longint'(1) << w) - 1;
    endfunction
endpackage

// File: rtl/nav_timer.sv
// nav_timer: loadable phase down-counter, expired while the count reads zero
//   clk, reset   clock and asynchronous active-high reset
//   load         load load_value this edge (takes priority over counting)
//   load_value   N-1 for a phase lasting N cycles
//   expired      count is zero
module nav_timer #(
    parameter int TIMER_W = 24
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               load,
    input  logic [TIMER_W-1:0] load_value,
    output logic               expired
);
    logic [TIMER_W-1:0] count;

    always_ff @(posedge clk or posedge reset)
        if (reset) count <= '0;
        else if (load) count <= load_value;
        else if (count != '0) count <= count - 1'b1;

    assign expired = count == '0;
endmodule

// File: rtl/obstacle_nav_controller.sv
// obstacle_nav_controller: forward/brake/reverse/turn rover navigation with retry limit
//   clk, reset        clock and asynchronous active-high reset
//   enable            run request; low forces IDLE
//   dist_valid        strobe qualifying distance_front/left/right
//   direction         registered one-hot motor direction
//   busy              registered, high in BRAKE, REVERSE, TURN_L, TURN_R
//   stuck             registered, high in FAULT
module obstacle_nav_controller import nav_pkg::*; #(
    parameter int DIST_W         = 16,
    parameter int OBST_THRESH    = 13,
    parameter int CLEAR_THRESH   = 20,
    parameter int TIMER_W        = 24,
    parameter int BRAKE_CYCLES   = 6250000,
    parameter int REVERSE_CYCLES = 12500000,
    parameter int TURN_CYCLES    = 12500000,
    parameter int MAX_RETRIES    = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic              dist_valid,
    input  logic [DIST_W-1:0] distance_front,
    input  logic [DIST_W-1:0] distance_left,
    input  logic [DIST_W-1:0] distance_right,
    output logic [4:0]        direction,
    output logic              busy,
    output logic              stuck
);
    if (CLEAR_THRESH <= OBST_THRESH) begin : g_bad_thresh
        $error("CLEAR_THRESH must be greater than OBST_THRESH");
    end
    if (MAX_RETRIES < 1 || MAX_RETRIES > 15) begin : g_bad_retries
        $error("MAX_RETRIES must be in 1..15");
    end
    if (!cycles_ok(longint'(BRAKE_CYCLES), TIMER_W) || !cycles_ok(longint'(REVERSE_CYCLES), TIMER_W) ||
        !cycles_ok(longint'(TURN_CYCLES), TIMER_W)) begin : g_bad_cycles
        $error("phase cycle counts must be in 1..2^TIMER_W-1");
    end

    state_t             state, next_state;
    logic               obstacle, load, expired;
    logic [DIST_W-1:0]  side_left, side_right;
    logic [3:0]         retries, next_retries;
    logic [TIMER_W-1:0] load_value;

    // Hysteresis: between the two thresholds the flag keeps its previous value.
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            obstacle   <= 1'b0;
            side_left  <= '0;
            side_right <= '0;
        end else if (dist_valid) begin
            obstacle   <= distance_front <= DIST_W'(OBST_THRESH)  ? 1'b1 :
                          distance_front >= DIST_W'(CLEAR_THRESH) ? 1'b0 : obstacle;
            side_left  <= distance_left;
            side_right <= distance_right;
        end

    always_comb begin
        next_state   = state;
        next_retries = retries;
        if (state != S_IDLE && !enable) begin
            next_state   = S_IDLE;
            next_retries = '0;
        end else begin
            case (state)
                S_IDLE:    if (enable) next_state = S_FORWARD;
                S_FORWARD: if (obstacle) next_state = S_BRAKE;
                S_BRAKE:   if (expired) next_state = S_REVERSE;
                S_REVERSE:
                    if (expired) begin
                        next_state   = side_left > side_right ? S_TURN_L : S_TURN_R;
                        next_retries = retries == 4'(MAX_RETRIES) ? retries : retries + 4'd1;
                    end
                S_TURN_L, S_TURN_R:
                    if (expired) begin
                        next_state   = !obstacle ? S_FORWARD :
                                       retries == 4'(MAX_RETRIES) ? S_FAULT : S_BRAKE;
                        next_retries = obstacle ? retries : '0;
                    end
                default: ;
            endcase
        end
    end

    // Timer is reloaded on every entry to a timed phase, including TURN -> BRAKE.
    assign load = next_state != state &&
                  next_state inside {S_BRAKE, S_REVERSE, S_TURN_L, S_TURN_R};
    assign load_value = next_state == S_BRAKE   ? TIMER_W'(BRAKE_CYCLES - 1) :
                        next_state == S_REVERSE ? TIMER_W'(REVERSE_CYCLES - 1) :
                                                  TIMER_W'(TURN_CYCLES - 1);

    nav_timer #(.TIMER_W(TIMER_W)) u_timer (
        .clk        (clk),
        .reset      (reset),
        .load       (load),
        .load_value (load_value),
        .expired    (expired)
    );

    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            state     <= S_IDLE;
            retries   <= '0;
            direction <= DIR_STOP;
            busy      <= 1'b0;
            stuck     <= 1'b0;
        end else begin
            state     <= next_state;
            retries   <= next_retries;
            direction <= dir_of(next_state);
            busy      <= next_state inside {S_BRAKE, S_REVERSE, S_TURN_L, S_TURN_R};
            stuck     <= next_state == S_FAULT;
        end
endmodule

// File: tb/tb_obstacle_nav_controller.sv
// tb_obstacle_nav_controller: directed scenarios plus random stimulus against a phase/age reference model
module tb_obstacle_nav_controller;
    localparam int BRK = 4, REV = 8, TRN = 6, MAXR = 2;
    localparam int I = 0, F = 1, B = 2, R = 3, TL = 4, TR = 5, X = 6;

    logic        clk = 0, reset = 1, enable = 0, dist_valid = 0;
    logic [15:0] distance_front = 0, distance_left = 0, distance_right = 0;
    logic [4:0]  direction;
    logic        busy, stuck;

    int vectors = 0, miscompares = 0;
    int ph, age, tries, ml, mr;
    logic obst;
    int dur[7] = '{0, 0, BRK, REV, TRN, TRN, 0};
    logic [4:0] dir_code[7] = '{5'b10000, 5'b00001, 5'b10000, 5'b00010, 5'b00100, 5'b01000, 5'b10000};

    obstacle_nav_controller #(
        .DIST_W(16), .OBST_THRESH(13), .CLEAR_THRESH(20), .TIMER_W(8),
        .BRAKE_CYCLES(BRK), .REVERSE_CYCLES(REV), .TURN_CYCLES(TRN), .MAX_RETRIES(MAXR)
    ) dut (
        .clk(clk), .reset(reset), .enable(enable), .dist_valid(dist_valid),
        .distance_front(distance_front), .distance_left(distance_left), .distance_right(distance_right),
        .direction(direction), .busy(busy), .stuck(stuck)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic void model_reset();
        ph = I; age = 0; tries = 0; obst = 1'b0; ml = 0; mr = 0;
    endfunction

    // One clock edge: the phase decision uses the flag/sides from before this edge,
    // then the strobe (if any) updates them for the following cycle.
    function automatic void model_edge();
        int  nph  = ph;
        bit  done = age + 1 == dur[ph];
        if (!enable && ph != I) begin
            nph = I; tries = 0;
        end else if (ph == I) begin
            if (enable) nph = F;
        end else if (ph == F) begin
            if (obst) nph = B;
        end else if (ph == B) begin
            if (done) nph = R;
        end else if (ph == R) begin
            if (done) begin
                nph   = ml > mr ? TL : TR;
                tries = tries < MAXR ? tries + 1 : MAXR;
            end
        end else if (ph == TL || ph == TR) begin
            if (done) begin
                if (!obst) begin nph = F; tries = 0; end
                else nph = tries == MAXR ? X : B;
            end
        end
        age = nph == ph ? age + 1 : 0;
        ph  = nph;
        if (dist_valid) begin
            obst = distance_front <= 13 ? 1'b1 : distance_front >= 20 ? 1'b0 : obst;
            ml = int'(distance_left);
            mr = int'(distance_right);
        end
    endfunction

    task automatic step(input logic en, input logic dv, input int f, input int l, input int r);
        enable = en; dist_valid = dv;
        distance_front = 16'(f); distance_left = 16'(l); distance_right = 16'(r);
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check("direction", 32'(direction), 32'(dir_code[ph]));
        check("busy", 32'(busy), 32'(ph >= B && ph <= TR));
        check("stuck", 32'(stuck), 32'(ph == X));
    endtask

    task automatic run_until(input int target, input int limit, input int f, input int l, input int r);
        int n = 0;
        while (ph != target && n < limit) begin
            step(1'b1, 1'b0, f, l, r);
            n++;
        end
        if (ph != target) begin
            miscompares++;
            $display("FAIL timeout_phase: got phase %0d expected %0d", ph, target);
        end
    endtask

    // Called right after a falling edge: asserts reset mid-cycle and checks the outputs react
    // before any clock edge.
    task automatic async_reset();
        #2 reset = 1'b1;
        #1;
        check("async_dir", 32'(direction), 32'(5'b10000));
        check("async_busy", 32'(busy), 32'(1'b0));
        check("async_stuck", 32'(stuck), 32'(1'b0));
        model_reset();
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_dir", 32'(direction), 32'(5'b10000));
        check("reset_busy", 32'(busy), 32'(1'b0));
        check("reset_stuck", 32'(stuck), 32'(1'b0));
        reset = 1'b0;

        // Obstacle with more room on the left, cleared during the turn.
        step(1'b1, 1'b0, 100, 0, 0);
        step(1'b1, 1'b1, 13, 40, 10);
        run_until(TL, 40, 100, 0, 0);
        step(1'b1, 1'b1, 30, 40, 10);
        run_until(F, 20, 100, 0, 0);

        // Hysteresis: 14 from clear does not set; 16 and 19 hold; 20 clears.
        step(1'b1, 1'b1, 14, 5, 6);
        step(1'b1, 1'b0, 0, 0, 0);
        step(1'b1, 1'b0, 0, 0, 0);
        step(1'b1, 1'b1, 12, 5, 6);
        run_until(B, 5, 0, 0, 0);
        step(1'b1, 1'b1, 16, 5, 6);
        step(1'b1, 1'b1, 19, 5, 6);
        run_until(TR, 30, 0, 0, 0);
        run_until(B, 10, 0, 0, 0);
        step(1'b1, 1'b1, 20, 30, 10);
        run_until(F, 40, 0, 0, 0);

        // Tie goes right; persistent obstacle exhausts retries and faults.
        step(1'b1, 1'b1, 5, 25, 25);
        run_until(X, 80, 0, 0, 0);
        check("fault_stuck", 32'(stuck), 32'(1'b1));
        check("fault_dir", 32'(direction), 32'(5'b10000));
        step(1'b1, 1'b1, 30, 40, 10);
        step(1'b1, 1'b0, 0, 0, 0);

        // Recovery from fault needs enable low; retries restart from zero.
        step(1'b0, 1'b1, 5, 9, 3);
        step(1'b1, 1'b0, 0, 0, 0);
        run_until(X, 80, 0, 0, 0);

        // Abort on the exact cycle BRAKE would expire.
        step(1'b0, 1'b0, 0, 0, 0);
        step(1'b1, 1'b0, 0, 0, 0);
        run_until(B, 5, 0, 0, 0);
        while (ph == B && age < BRK - 1) step(1'b1, 1'b0, 0, 0, 0);
        step(1'b0, 1'b0, 0, 0, 0);
        check("abort_busy", 32'(busy), 32'(1'b0));
        step(1'b1, 1'b0, 0, 0, 0);

        // Asynchronous reset in the middle of REVERSE.
        run_until(R, 20, 0, 0, 0);
        step(1'b1, 1'b0, 0, 0, 0);
        step(1'b1, 1'b0, 0, 0, 0);
        async_reset();
        step(1'b1, 1'b0, 0, 0, 0);
        check("post_reset_fwd", 32'(direction), 32'(5'b00001));

        for (int i = 0; i < 4000; i++) begin
            int f = int'($urandom_range(0, 30));
            int l = int'($urandom_range(0, 40));
            int r = $urandom_range(0, 3) == 0 ? l : int'($urandom_range(0, 40));
            step($urandom_range(0, 99) != 0, $urandom_range(0, 3) == 0, f, l, r);
            if ($urandom_range(0, 999) == 0) async_reset();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/obstacle_nav_controller.md
Name: obstacle_nav_controller

Overview:
Parametrised successor to the single-sensor motor controller. Drives the rover forward and brakes when the front sensor reports an obstacle. It then reverses and turns towards the side with more clearance, retrying up to a limit before latching a stuck fault. It sits between the ultrasonic distance front-ends and the motor driver, and emits the existing one-hot direction code.

Parameters:
DIST_W, 16, width of every distance input (sensor units)
OBST_THRESH, 13, front distance at or below this value sets the obstacle flag
CLEAR_THRESH, 20, front distance at or above this value clears the obstacle flag (must be > OBST_THRESH)
TIMER_W, 24, width of the phase down-counter
BRAKE_CYCLES, 6250000, cycles spent in BRAKE (50 ms at 125 MHz)
REVERSE_CYCLES, 12500000, cycles spent in REVERSE
TURN_CYCLES, 12500000, cycles spent in TURN_L or TURN_R
MAX_RETRIES, 3, number of turn attempts before FAULT (range 1..15)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
enable  in  1  run request; low forces IDLE
dist_valid  in  1  single-cycle strobe; all three distances are valid this cycle
distance_front  in  DIST_W  front range
distance_left  in  DIST_W  left range
distance_right  in  DIST_W  right range
direction  out  5  one-hot: FORWARD 00001, BACKWARD 00010, LEFT 00100, RIGHT 01000, STOP 10000
busy  out  1  high in BRAKE, REVERSE, TURN_L and TURN_R
stuck  out  1  high in FAULT

Behaviour:
- Reset (async, any time): state IDLE, direction=10000, busy=0, stuck=0, obstacle=0, retry count=0, timer=0, latched side distances=0.
- Obstacle flag, with hysteresis, is updated only on dist_valid:
  - set if front <= OBST_THRESH
  - clear if front >= CLEAR_THRESH
  - held otherwise, and held when dist_valid=0.
- On dist_valid, distance_left and distance_right are latched into side registers.
- The FSM sees the updated flag and side registers one cycle after the strobe.
- All outputs are registered and computed from next-state, so direction, busy and stuck change on the same edge as the state.
- State to direction: IDLE=STOP, FORWARD=FORWARD, BRAKE=STOP, REVERSE=BACKWARD, TURN_L=LEFT, TURN_R=RIGHT, FAULT=STOP.
- Timer: loaded with N-1 on entry to a timed state, decrements each cycle, expired when it reads 0. Each timed state therefore lasts exactly N cycles.
- Transitions, highest priority first:
  - Any state except IDLE with enable=0 -> IDLE, retries cleared, stuck cleared. This abort overrides timer expiry.
  - IDLE with enable=1 -> FORWARD.
  - FORWARD with obstacle=1 -> BRAKE, timer loaded with BRAKE_CYCLES.
  - BRAKE expired -> REVERSE, timer loaded with REVERSE_CYCLES.
  - REVERSE expired -> TURN_L if latched left > latched right, else TURN_R (a tie goes right). Timer loaded with TURN_CYCLES; retries incremented.
  - TURN expired with obstacle=0 -> FORWARD, retries cleared.
  - TURN expired with obstacle=1 and retries==MAX_RETRIES -> FAULT.
  - TURN expired with obstacle=1 otherwise -> BRAKE.
  - FAULT is held until enable=0.
- A dist_valid strobe during BRAKE or REVERSE may clear the flag; the FSM still completes the current phase.
- Retry counter is 4 bits and saturates at MAX_RETRIES.
- Elaboration check: each *_CYCLES value must be in 1..2^TIMER_W-1.

Decomposition:
- nav_pkg holds the direction one-hot localparams (DIR_FORWARD, DIR_BACKWARD, DIR_LEFT, DIR_RIGHT, DIR_STOP) and the state encoding. The package is shared with the motor driver and top level.
- Sub-module nav_timer, parametrised by TIMER_W: inputs load and load_value, outputs expired. It is the generalised form of the existing start/expired timer.

Test Plan:
All scenarios use BRAKE_CYCLES=4, REVERSE_CYCLES=8, TURN_CYCLES=6, MAX_RETRIES=2.
1. Reset asserted mid-REVERSE -> direction=10000, busy=0 asynchronously; after release with enable=1, FORWARD on the next edge.
2. In FORWARD, dist_valid with front=13, left=40, right=10 -> the edge after the flag sets gives STOP for 4 cycles, BACKWARD for 8 cycles, then LEFT for 6 cycles. If a strobe with front=30 arrives during the turn, the next state is FORWARD.
3. Hysteresis: front sequence 12, 16, 19 (flag stays set) then 20 (clears). Also 14 from a clear state -> no set.
4. Tie left=right=25 -> TURN_R. Front stays at 5 -> BRAKE/REVERSE/TURN repeats twice, then FAULT with stuck=1 and direction=10000.
5. Drop enable in BRAKE on the same cycle as timer expiry -> IDLE (not REVERSE) next cycle, busy=0.
6. From FAULT, enable=0 then enable=1 -> stuck clears and FORWARD resumes with retries=0.
